// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/control unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register $zero never carries a dependency, so it never matches.
    function automatic logic reg_match(input logic [4:0] dest, input logic [4:0] src);
        return (dest != 5'd0) && (dest == src);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EX operand: the MEM-stage result beats the WB-stage result.
module fwd_sel (
    input  logic [4:0] src,
    input  logic       mem_reg_write,
    input  logic       mem_mem_read,
    input  logic [4:0] mem_reg_dest,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_reg_dest,
    output logic [1:0] fwd
);
    import hazard_pkg::*;

    // A load in MEM has no data yet, so it cannot feed EX from the MEM stage.
    always_comb begin
        fwd = FWD_RF;
        if (mem_reg_write && !mem_mem_read && reg_match(mem_reg_dest, src)) begin
            fwd = FWD_MEM;
        end else if (wb_reg_write && reg_match(wb_reg_dest, src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall/flush/freeze priority, EX forwarding, data-memory
// wait FSM with watchdog, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STALL_CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             ID_rs,
    input  logic [4:0]             ID_rt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_Jump,
    input  logic [4:0]             EX_rs,
    input  logic [4:0]             EX_rt,
    input  logic                   EX_MemRead,
    input  logic [4:0]             EX_RegDest,
    input  logic                   EX_BranchTaken,
    input  logic                   MEM_RegWrite,
    input  logic                   MEM_MemRead,
    input  logic                   MEM_MemWrite,
    input  logic [4:0]             MEM_RegDest,
    input  logic                   WB_RegWrite,
    input  logic [4:0]             WB_RegDest,
    input  logic                   dmem_ack,
    input  logic                   stat_clr,
    output logic                   IF_stall,
    output logic                   IFID_stall,
    output logic                   IFID_flush,
    output logic                   IDEX_flush,
    output logic                   freeze,
    output logic                   dmem_req,
    output logic [1:0]             ForwardA,
    output logic [1:0]             ForwardB,
    output logic                   mem_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);
    import hazard_pkg::*;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                   state_reg;
    logic [WAIT_W-1:0]        wait_cnt_reg;
    logic                     mem_timeout_reg;
    logic [STALL_CNT_W-1:0]   stall_count_reg;

    logic memop;
    logic mem_stall;
    logic load_use;
    logic in_err;

    logic [4:0] src_arr [2];
    logic [1:0] fwd_arr [2];

    assign memop     = MEM_MemRead | MEM_MemWrite;
    assign mem_stall = memop & ~dmem_ack;
    assign in_err    = (state_reg == MEM_ERR);
    assign load_use  = EX_MemRead &
                       (reg_match(EX_RegDest, ID_rs) |
                        (ID_UsesRt & reg_match(EX_RegDest, ID_rt)));

    assign src_arr[0] = EX_rs;
    assign src_arr[1] = EX_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_sel u_fwd_sel (
                .src           (src_arr[gi]),
                .mem_reg_write (MEM_RegWrite),
                .mem_mem_read  (MEM_MemRead),
                .mem_reg_dest  (MEM_RegDest),
                .wb_reg_write  (WB_RegWrite),
                .wb_reg_dest   (WB_RegDest),
                .fwd           (fwd_arr[gi])
            );
        end
    endgenerate

    // Outputs are held at zero while reset is low, even though they are combinational.
    always_comb begin
        IF_stall   = 1'b0;
        IFID_stall = 1'b0;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        freeze     = 1'b0;
        dmem_req   = 1'b0;
        ForwardA   = FWD_RF;
        ForwardB   = FWD_RF;
        if (reset) begin
            if (in_err) begin
                freeze = 1'b1;
            end else begin
                freeze   = mem_stall;
                dmem_req = memop;
                ForwardA = fwd_arr[0];
                ForwardB = fwd_arr[1];
                if (!mem_stall) begin
                    if (EX_BranchTaken) begin
                        IFID_flush = 1'b1;
                        IDEX_flush = 1'b1;
                    end else if (load_use) begin
                        // A jump waiting behind a load-use stall stays in ID and retries.
                        IF_stall   = 1'b1;
                        IFID_stall = 1'b1;
                        IDEX_flush = 1'b1;
                    end else if (ID_Jump) begin
                        IFID_flush = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (mem_stall) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES)) begin
                        state_reg       <= MEM_ERR;
                        mem_timeout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                MEM_ERR: begin
                    state_reg <= MEM_ERR;
                end
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_reg <= '0;
        end else if (stat_clr) begin
            stall_count_reg <= '0;
        end else if ((IF_stall | freeze) && !in_err && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + STALL_CNT_W'(1);
        end
    end

    assign mem_timeout = mem_timeout_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (small timeout and counter width).
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] ID_rs, ID_rt;
    logic       ID_UsesRt, ID_Jump;
    logic [4:0] EX_rs, EX_rt;
    logic       EX_MemRead;
    logic [4:0] EX_RegDest;
    logic       EX_BranchTaken;
    logic       MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic [4:0] MEM_RegDest;
    logic       WB_RegWrite;
    logic [4:0] WB_RegDest;
    logic       dmem_ack, stat_clr;
    logic       IF_stall, IFID_stall, IFID_flush, IDEX_flush, freeze, dmem_req;
    logic [1:0] ForwardA, ForwardB;
    logic       mem_timeout;
    logic [3:0] stall_count;
    logic [5:0] ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.TIMEOUT_CYCLES(4), .STALL_CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt), .ID_Jump(ID_Jump),
        .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest),
        .EX_BranchTaken(EX_BranchTaken),
        .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_RegDest(MEM_RegDest), .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
        .dmem_ack(dmem_ack), .stat_clr(stat_clr),
        .IF_stall(IF_stall), .IFID_stall(IFID_stall), .IFID_flush(IFID_flush),
        .IDEX_flush(IDEX_flush), .freeze(freeze), .dmem_req(dmem_req),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    // {IF_stall, IFID_stall, IFID_flush, IDEX_flush, freeze, dmem_req}
    assign ctrl = {IF_stall, IFID_stall, IFID_flush, IDEX_flush, freeze, dmem_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "bench time limit expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs = 0; ID_rt = 0; ID_UsesRt = 0; ID_Jump = 0;
        EX_rs = 0; EX_rt = 0; EX_MemRead = 0; EX_RegDest = 0; EX_BranchTaken = 0;
        MEM_RegWrite = 0; MEM_MemRead = 0; MEM_MemWrite = 0; MEM_RegDest = 0;
        WB_RegWrite = 0; WB_RegDest = 0; dmem_ack = 0; stat_clr = 0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        MEM_MemRead = 1; EX_BranchTaken = 1;
        #2;
        $display("step reset: inputs active while reset low");
        chk("reset_ctrl", {2'b0, ctrl}, 8'h00);
        chk("reset_cnt", {4'b0, stall_count}, 8'h00);
        chk("reset_timeout", {7'b0, mem_timeout}, 8'h00);
        #10;
        reset = 1'b1;
        clear_inputs();
        tick();

        $display("step load-use on rs");
        EX_MemRead = 1; EX_RegDest = 5; ID_rs = 5;
        #1 chk("lu_rs", {2'b0, ctrl}, 8'b00110100);
        tick();
        clear_inputs();
        #1 chk("lu_gone", {2'b0, ctrl}, 8'h00);
        chk("cnt_after_lu", {4'b0, stall_count}, 8'd1);
        tick();

        $display("step load-use on rt without UsesRt");
        EX_MemRead = 1; EX_RegDest = 5; ID_rt = 5; ID_UsesRt = 0;
        #1 chk("lu_rt_unused", {2'b0, ctrl}, 8'h00);
        tick();
        $display("step load-use on rt with UsesRt");
        ID_UsesRt = 1;
        #1 chk("lu_rt_used", {2'b0, ctrl}, 8'b00110100);
        tick();
        $display("step load to r0 never stalls");
        EX_RegDest = 0; ID_rs = 0; ID_rt = 0;
        #1 chk("lu_r0", {2'b0, ctrl}, 8'h00);
        tick();

        $display("step load-use with jump");
        clear_inputs();
        EX_MemRead = 1; EX_RegDest = 5; ID_rs = 5; ID_Jump = 1;
        #1 chk("lu_jump", {2'b0, ctrl}, 8'b00110100);
        tick();
        $display("step jump alone");
        EX_MemRead = 0;
        #1 chk("jump", {2'b0, ctrl}, 8'b00001000);
        tick();
        $display("step branch with load-use");
        ID_Jump = 0; EX_MemRead = 1; EX_BranchTaken = 1;
        #1 chk("branch_lu", {2'b0, ctrl}, 8'b00001100);
        tick();
        chk("cnt_after_branch", {4'b0, stall_count}, 8'd3);

        $display("step memory wait, ack after 3 cycles");
        clear_inputs();
        MEM_MemRead = 1; EX_BranchTaken = 1;
        #1 chk("memw_c0", {2'b0, ctrl}, 8'b00000011);
        tick();
        EX_BranchTaken = 0;
        #1 chk("memw_c1", {2'b0, ctrl}, 8'b00000011);
        tick();
        #1 chk("memw_c2", {2'b0, ctrl}, 8'b00000011);
        tick();
        dmem_ack = 1;
        #1 chk("memw_ack", {2'b0, ctrl}, 8'b00000001);
        tick();
        chk("cnt_after_wait", {4'b0, stall_count}, 8'd6);
        clear_inputs();
        MEM_MemWrite = 1; dmem_ack = 1;
        #1 chk("memw_fast", {2'b0, ctrl}, 8'b00000001);
        tick();
        chk("cnt_after_fast", {4'b0, stall_count}, 8'd6);

        $display("step forwarding");
        clear_inputs();
        MEM_RegWrite = 1; MEM_RegDest = 7; WB_RegWrite = 1; WB_RegDest = 7; EX_rs = 7;
        #1 chk("fwdA_mem", {6'b0, ForwardA}, 8'b10);
        chk("fwdB_rf", {6'b0, ForwardB}, 8'b00);
        MEM_MemRead = 1; dmem_ack = 1;
        #1 chk("fwdA_wb_load", {6'b0, ForwardA}, 8'b01);
        EX_rt = 7;
        #1 chk("fwdB_wb", {6'b0, ForwardB}, 8'b01);
        MEM_MemRead = 0; MEM_RegDest = 0; WB_RegDest = 0; EX_rs = 0; EX_rt = 0;
        #1 chk("fwdA_r0", {6'b0, ForwardA}, 8'b00);
        tick();

        $display("step stat_clr with stall");
        clear_inputs();
        EX_MemRead = 1; EX_RegDest = 5; ID_rs = 5; stat_clr = 1;
        tick();
        chk("cnt_clr", {4'b0, stall_count}, 8'd0);
        stat_clr = 0;
        $display("step counter saturation");
        for (int i = 0; i < 14; i++) tick();
        chk("cnt_14", {4'b0, stall_count}, 8'd14);
        tick();
        chk("cnt_15", {4'b0, stall_count}, 8'd15);
        tick();
        chk("cnt_sat", {4'b0, stall_count}, 8'd15);
        clear_inputs();
        stat_clr = 1;
        tick();
        stat_clr = 0;
        chk("cnt_clr2", {4'b0, stall_count}, 8'd0);

        $display("step timeout with no ack");
        clear_inputs();
        MEM_MemRead = 1; WB_RegWrite = 1; WB_RegDest = 7; EX_rs = 7;
        EX_MemRead = 1; EX_RegDest = 5; ID_rs = 5;
        #1 chk("to_fwd_before", {6'b0, ForwardA}, 8'b01);
        for (int i = 0; i < 4; i++) tick();
        chk("to_not_yet", {7'b0, mem_timeout}, 8'd0);
        chk("to_wait_ctrl", {2'b0, ctrl}, 8'b00000011);
        tick();
        chk("to_flag", {7'b0, mem_timeout}, 8'd1);
        chk("to_err_ctrl", {2'b0, ctrl}, 8'b00000010);
        chk("to_err_fwd", {6'b0, ForwardA}, 8'b00);
        chk("to_cnt", {4'b0, stall_count}, 8'd5);
        dmem_ack = 1;
        tick();
        tick();
        chk("to_sticky_ctrl", {2'b0, ctrl}, 8'b00000010);
        chk("to_sticky_cnt", {4'b0, stall_count}, 8'd5);

        $display("step reset out of MEM_ERR");
        #2 reset = 1'b0;
        #1 chk("rst_err_ctrl", {2'b0, ctrl}, 8'h00);
        chk("rst_err_flag", {7'b0, mem_timeout}, 8'd0);
        chk("rst_err_cnt", {4'b0, stall_count}, 8'd0);
        clear_inputs();
        #2 reset = 1'b1;
        tick();
        chk("run_after_rst", {2'b0, ctrl}, 8'h00);
        MEM_MemRead = 1; dmem_ack = 1;
        #1 chk("run_mem_ack", {2'b0, ctrl}, 8'b00000001);
        dmem_ack = 0;
        #1 chk("run_mem_wait", {2'b0, ctrl}, 8'b00000011);
        tick();
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control unit on the driving side of the stage-register interface. It drives the stall, flush and freeze inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also drives the EX-stage forwarding selects. It owns the data-memory wait handshake through a small FSM with a watchdog and keeps a saturating stall-cycle counter.

## Interface
- TIMEOUT_CYCLES, 255: number of wait cycles without dmem_ack before the unit declares a memory fault.
- STALL_CNT_W, 16: width of stall_count.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
- ID_UsesRt  in  1  the ID instruction reads rt.
- ID_Jump  in  1  jump resolved in ID.
- EX_rs, EX_rt  in  5 each  source registers in EX.
- EX_MemRead  in  1  EX instruction is a load.
- EX_RegDest  in  5  EX destination register.
- EX_BranchTaken  in  1  branch resolved taken in EX.
- MEM_RegWrite, MEM_MemRead, MEM_MemWrite  in  1 each  MEM-stage controls.
- MEM_RegDest  in  5  MEM-stage destination register.
- WB_RegWrite  in  1  WB-stage register write.
- WB_RegDest  in  5  WB-stage destination register.
- dmem_ack  in  1  data memory completes the current access.
- stat_clr  in  1  synchronous clear of stall_count.
- IF_stall  out  1  hold PC.
- IFID_stall  out  1  hold the IF/ID register.
- IFID_flush  out  1  zero the IF/ID register on the next edge.
- IDEX_flush  out  1  insert a bubble into ID/EX.
- freeze  out  1  hold every stage register and the PC.
- dmem_req  out  1  memory access request.
- ForwardA, ForwardB  out  2 each  EX operand select: 00 regfile, 01 WB, 10 MEM.
- mem_timeout  out  1  sticky memory-fault flag.
- stall_count  out  STALL_CNT_W  saturating count of stall and freeze cycles.

## Operation
- FSM states:
  - RUN
  - MEM_WAIT
  - MEM_ERR
- memop = MEM_MemRead | MEM_MemWrite.
- dmem_req = memop, except in MEM_ERR, where it is 0.
- freeze = memop & ~dmem_ack in RUN or MEM_WAIT. In MEM_ERR, freeze = 1.
- RUN:
  - memop & ~dmem_ack → MEM_WAIT, wait counter loaded with 1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - dmem_ack → RUN.
  - Otherwise the wait counter increments.
  - Wait counter == TIMEOUT_CYCLES without ack → MEM_ERR and mem_timeout set.
- MEM_ERR: terminal until reset. freeze=1, all other control outputs 0.
- Load-use hazard: EX_MemRead & EX_RegDest≠0 & (EX_RegDest==ID_rs | (ID_UsesRt & EX_RegDest==ID_rt)).
  - Response: IF_stall=1, IFID_stall=1, IDEX_flush=1 for that cycle.
- Branch: EX_BranchTaken → IFID_flush=1 and IDEX_flush=1.
- Jump: ID_Jump → IFID_flush=1.
- Priority, highest first:
  1. freeze: all stall and flush outputs 0, since the freeze hold dominates.
  2. Branch: load-use stall suppressed.
  3. Load-use.
  4. Jump.
- Load-use and ID_Jump in the same cycle: stall only, no IFID_flush. The jump stays in ID and re-evaluates next cycle.
- Forwarding, computed separately for ForwardA (EX_rs) and ForwardB (EX_rt):
  - MEM match, MEM_RegWrite & ~MEM_MemRead & MEM_RegDest≠0 & MEM_RegDest==src → 10.
  - Otherwise WB match, WB_RegWrite & WB_RegDest≠0 & WB_RegDest==src → 01.
  - Otherwise 00.
  - The MEM match wins over the WB match.
- stall_count:
  - Increments when (IF_stall | freeze) in RUN or MEM_WAIT.
  - Saturates at all-ones.
  - stat_clr has priority over the increment.

## Timing
- All stall, flush, freeze, dmem_req and forward outputs are combinational from the inputs and the registered state.
- The stage registers act on the following posedge.
- A load-use hazard costs exactly one bubble. Next cycle the load is in MEM and the hazard is gone.
- A taken branch costs two squashed instructions.
- A memory access with ack in the first cycle costs zero freeze cycles. N wait cycles cost N freeze cycles.
- Reset is asserted asynchronously:
  - state=RUN, wait counter=0, mem_timeout=0, stall_count=0.
  - All outputs are forced to 0 while reset is low.
  - Reset during MEM_WAIT or MEM_ERR returns to RUN with no residual freeze.
- Wait-counter width is ceil(log2(TIMEOUT_CYCLES+1)). It is not used in RUN.

## Structure
- Package hazard_pkg holds:
  - the state enum {RUN, MEM_WAIT, MEM_ERR};
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module fwd_sel: comparator and priority for one operand, instantiated twice (rs, rt).
- The top level holds the FSM, the priority logic and the counters.

## Test plan
- Load-use: EX_MemRead=1, EX_RegDest=5, ID_rs=5 → IF_stall=IFID_stall=IDEX_flush=1 for one cycle. Same case with ID_rt=5 and ID_UsesRt=0 → no stall.
- Branch and hazard together: EX_BranchTaken=1 with a simultaneous load-use → IFID_flush=IDEX_flush=1, IF_stall=0.
- Memory wait: MEM_MemRead=1, dmem_ack arrives after 3 cycles → freeze high exactly 3 cycles, stall_count +3, state back to RUN.
- Timeout: TIMEOUT_CYCLES=4, no ack → MEM_ERR entered, mem_timeout=1, freeze stuck high, dmem_req=0. Releasing reset returns to RUN with all outputs 0.
- Forwarding:
  - MEM_RegDest=WB_RegDest=EX_rs=7, both RegWrite → ForwardA=10.
  - MEM_MemRead=1 → ForwardA=01.
  - Dest=0 → ForwardA=00.
- Counter: stat_clr together with a stall → stall_count=0. Preload near all-ones and stall → stall_count saturates.
